// File: rtl/ahb_bm_pkg.sv
// Shared AHB encodings and held-transfer rewrite helpers for the bus matrix input stage.
package ahb_bm_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // {hold_valid, data_phase}
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_DATA      = 2'b01,
      ST_HOLD      = 2'b10,
      ST_HOLD_DATA = 2'b11
   } in_state_t;

   // Another master may have interleaved while we waited, so a held burst restarts as NONSEQ/INCR.
   function automatic logic [1:0] held_trans(input logic [1:0] trans);
      return (trans == HTRANS_SEQ) ? HTRANS_NONSEQ : trans;
   endfunction

   function automatic logic [2:0] held_burst(input logic [2:0] burst);
      return (burst != HBURST_SINGLE) ? HBURST_INCR : burst;
   endfunction

endpackage

// File: rtl/ahb_bm_input_stage_hold_reg.sv
// Enable-captured holding register for one master's address/control phase.
module ahb_bm_hold_reg
   import ahb_bm_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MASTER_W = 4
)(
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                capture,
   input  logic                sel,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [1:0]          trans,
   input  logic                write,
   input  logic [2:0]          size,
   input  logic [2:0]          burst,
   input  logic [3:0]          prot,
   input  logic [MASTER_W-1:0] master,
   input  logic                mastlock,
   output logic                held_sel,
   output logic [ADDR_W-1:0]   held_addr,
   output logic [1:0]          held_trans_q,
   output logic                held_write,
   output logic [2:0]          held_size,
   output logic [2:0]          held_burst_q,
   output logic [3:0]          held_prot,
   output logic [MASTER_W-1:0] held_master,
   output logic                held_mastlock
);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         held_sel      <= 1'b0;
         held_addr     <= '0;
         held_trans_q  <= HTRANS_IDLE;
         held_write    <= 1'b0;
         held_size     <= '0;
         held_burst_q  <= HBURST_SINGLE;
         held_prot     <= '0;
         held_master   <= '0;
         held_mastlock <= 1'b0;
      end else if (capture) begin
         held_sel      <= sel;
         held_addr     <= addr;
         held_trans_q  <= trans;
         held_write    <= write;
         held_size     <= size;
         held_burst_q  <= burst;
         held_prot     <= prot;
         held_master   <= master;
         held_mastlock <= mastlock;
      end
   end

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Per-master AHB bus matrix input stage: zero-latency pass-through, holds and stalls on arbitration loss.
// Optional held-cycle statistics counter enabled by defining AHB_BM_IN_HOLD_STATS_EN.
module ahb_bm_input_stage
   import ahb_bm_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MASTER_W = 4,
   parameter int CNT_W    = 16
)(
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                HSELS,
   input  logic [ADDR_W-1:0]   HADDRS,
   input  logic [1:0]          HTRANSS,
   input  logic                HWRITES,
   input  logic [2:0]          HSIZES,
   input  logic [2:0]          HBURSTS,
   input  logic [3:0]          HPROTS,
   input  logic [MASTER_W-1:0] HMASTERS,
   input  logic                HMASTLOCKS,
   input  logic [DATA_W-1:0]   HWDATAS,
   input  logic                HREADYS,
   input  logic                active_ip,
   input  logic                readyout_ip,
   input  logic                resp_ip,
   output logic                sel_ip,
   output logic [ADDR_W-1:0]   addr_ip,
   output logic [1:0]          trans_ip,
   output logic                write_ip,
   output logic [2:0]          size_ip,
   output logic [2:0]          burst_ip,
   output logic [3:0]          prot_ip,
   output logic [MASTER_W-1:0] master_ip,
   output logic                mastlock_ip,
   output logic [DATA_W-1:0]   wdata_ip,
   output logic                held_tran_ip,
   output logic                HREADYOUTS,
   output logic                HRESPS,
   output logic [CNT_W-1:0]    held_cnt
);

   in_state_t state, state_nxt;
   logic hold_valid, data_phase;
   logic new_tran, capture, release_hold, accept;
   logic hold_nxt, data_nxt;

   logic                h_sel, h_write, h_mastlock;
   logic [ADDR_W-1:0]   h_addr;
   logic [1:0]          h_trans;
   logic [2:0]          h_size, h_burst;
   logic [3:0]          h_prot;
   logic [MASTER_W-1:0] h_master;

   assign hold_valid = state[1];
   assign data_phase = state[0];

   assign new_tran     = HSELS & HTRANSS[1] & HREADYS;
   assign capture      = ~hold_valid & new_tran & ~active_ip;
   assign accept       = ~hold_valid & new_tran & active_ip;
   assign release_hold = hold_valid & active_ip & readyout_ip;

   ahb_bm_hold_reg #(
      .ADDR_W   (ADDR_W),
      .MASTER_W (MASTER_W)
   ) u_hold_reg (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .capture       (capture),
      .sel           (HSELS),
      .addr          (HADDRS),
      .trans         (HTRANSS),
      .write         (HWRITES),
      .size          (HSIZES),
      .burst         (HBURSTS),
      .prot          (HPROTS),
      .master        (HMASTERS),
      .mastlock      (HMASTLOCKS),
      .held_sel      (h_sel),
      .held_addr     (h_addr),
      .held_trans_q  (h_trans),
      .held_write    (h_write),
      .held_size     (h_size),
      .held_burst_q  (h_burst),
      .held_prot     (h_prot),
      .held_master   (h_master),
      .held_mastlock (h_mastlock)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // A data phase persists until readyout_ip, unless an accepted transfer opens the next one.
   always_comb begin
      hold_nxt  = capture | (hold_valid & ~release_hold);
      data_nxt  = release_hold | accept | (data_phase & ~readyout_ip);
      state_nxt = in_state_t'({hold_nxt, data_nxt});
   end

   always_comb begin
      sel_ip       = HSELS;
      addr_ip      = HADDRS;
      trans_ip     = HTRANSS;
      write_ip     = HWRITES;
      size_ip      = HSIZES;
      burst_ip     = HBURSTS;
      prot_ip      = HPROTS;
      master_ip    = HMASTERS;
      mastlock_ip  = HMASTLOCKS;
      held_tran_ip = HSELS & HTRANSS[1];
      if (hold_valid) begin
         sel_ip       = h_sel;
         addr_ip      = h_addr;
         trans_ip     = held_trans(h_trans);
         write_ip     = h_write;
         size_ip      = h_size;
         burst_ip     = held_burst(h_burst);
         prot_ip      = h_prot;
         master_ip    = h_master;
         mastlock_ip  = h_mastlock;
         held_tran_ip = 1'b1;
      end
      if (hold_valid)      HREADYOUTS = 1'b0;
      else if (data_phase) HREADYOUTS = readyout_ip;
      else                 HREADYOUTS = 1'b1;
      HRESPS = data_phase ? resp_ip : HRESP_OKAY;
   end

   assign wdata_ip = HWDATAS;

`ifdef AHB_BM_IN_HOLD_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         cnt_q <= '0;
      else if (hold_valid && (cnt_q != {CNT_W{1'b1}}))
         cnt_q <= cnt_q + 1'b1;
   end

   assign held_cnt = cnt_q;
`else
   assign held_cnt = '0;
`endif

endmodule
